// File: rtl/jedro_1_test_monitor_if.sv
// Regfile read port between the jedro_1 test monitor (master) and the regfile it inspects (slave).
interface jedro_1_test_monitor_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic [REG_ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0]     rf_data;

  modport master (output rf_addr, input  rf_data);
  modport slave  (input  rf_addr, output rf_data);
endinterface

// File: rtl/jedro_1_test_monitor.sv
// Run/check monitor for jedro_1 regression: run until stop, drain, compare regfile entries, report.
// Optional JEDRO_1_MON_ERR_CNT_EN: check every entry and count mismatches on err_cnt_o.
module jedro_1_test_monitor #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_CHECKS     = 2,
  parameter int MAX_CYCLES     = 32,
  parameter int DRAIN_CYCLES   = 3,
  parameter int CNT_WIDTH      = 16,
  localparam int NC_SAFE       = (NUM_CHECKS > 0) ? NUM_CHECKS : 1,
  localparam int IDX_W         = (NUM_CHECKS > 0) ? $clog2(NUM_CHECKS + 1) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          illegal_instr_i,
  input  logic                          halt_i,
  input  logic [NC_SAFE*REG_ADDR_WIDTH-1:0] exp_addr_i,
  input  logic [NC_SAFE*DATA_WIDTH-1:0] exp_data_i,
  jedro_1_test_monitor_if.master        rf_if,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          pass_o,
  output logic                          fail_o,
  output logic [1:0]                    stop_cause_o,
  output logic [IDX_W-1:0]              fail_idx_o,
  output logic [DATA_WIDTH-1:0]         fail_data_o,
`ifdef JEDRO_1_MON_ERR_CNT_EN
  output logic [CNT_WIDTH-1:0]          err_cnt_o,
`endif
  output logic [CNT_WIDTH-1:0]          cycle_cnt_o
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CHECK, S_DONE} state_e;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_HALT    = 2'd3;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NC_SAFE - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_AT = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(DRAIN_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0]    drain_cnt_q, drain_cnt_d;
  logic [IDX_W-1:0]        k_q, k_d;
  logic [1:0]              stop_cause_q, stop_cause_d;
  logic                    pass_q, pass_d;
  logic                    fail_q, fail_d;
  logic [IDX_W-1:0]        fail_idx_q, fail_idx_d;
  logic [DATA_WIDTH-1:0]   fail_data_q, fail_data_d;
`ifdef JEDRO_1_MON_ERR_CNT_EN
  logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
`endif

  logic [REG_ADDR_WIDTH-1:0] exp_addr_arr [NC_SAFE];
  logic [DATA_WIDTH-1:0]     exp_data_arr [NC_SAFE];
  logic [REG_ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]     cur_data;
  logic [REG_ADDR_WIDTH-1:0] rf_addr;
  logic                      stop;
  logic [1:0]                cause;
  logic                      mismatch;

  genvar gi;
  generate
    for (gi = 0; gi < NC_SAFE; gi++) begin : g_unpack
      assign exp_addr_arr[gi] = exp_addr_i[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      assign exp_data_arr[gi] = exp_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    cur_addr = '0;
    cur_data = '0;
    for (int i = 0; i < NC_SAFE; i++) begin
      if (k_q == IDX_W'(i)) begin
        cur_addr = exp_addr_arr[i];
        cur_data = exp_data_arr[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cycle_cnt_d  = cycle_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    k_d          = k_q;
    stop_cause_d = stop_cause_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    fail_idx_d   = fail_idx_q;
    fail_data_d  = fail_data_q;
`ifdef JEDRO_1_MON_ERR_CNT_EN
    err_cnt_d    = err_cnt_q;
`endif
    rf_addr      = '0;
    stop         = 1'b0;
    cause        = 2'd0;
    mismatch     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d      = S_RUN;
          cycle_cnt_d  = '0;
          stop_cause_d = 2'd0;
          pass_d       = 1'b0;
          fail_d       = 1'b0;
          fail_idx_d   = '0;
          fail_data_d  = '0;
`ifdef JEDRO_1_MON_ERR_CNT_EN
          err_cnt_d    = '0;
`endif
        end
      end
      S_RUN: begin
        cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_WIDTH'(1);
        if (illegal_instr_i) begin
          stop  = 1'b1;
          cause = CAUSE_ILLEGAL;
        end else if (halt_i) begin
          stop  = 1'b1;
          cause = CAUSE_HALT;
        end else if (cycle_cnt_q == TIMEOUT_AT) begin
          stop  = 1'b1;
          cause = CAUSE_TIMEOUT;
        end
        if (stop) begin
          stop_cause_d = cause;
          drain_cnt_d  = '0;
          k_d          = '0;
          state_d      = (DRAIN_CYCLES == 0) ? S_CHECK : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_CHECK;
          k_d     = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_WIDTH'(1);
        end
      end
      S_CHECK: begin
        if (NUM_CHECKS == 0) begin
          state_d = S_DONE;
          pass_d  = 1'b1;
        end else begin
          rf_addr  = cur_addr;
          mismatch = (rf_if.rf_data != cur_data);
`ifdef JEDRO_1_MON_ERR_CNT_EN
          // Only the first mismatch of a run is recorded; later ones just count.
          if (mismatch) begin
            if (err_cnt_q == '0) begin
              fail_idx_d  = k_q;
              fail_data_d = rf_if.rf_data;
            end
            err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_WIDTH'(1);
          end
          if (k_q == LAST_IDX) begin
            state_d = S_DONE;
            pass_d  = (err_cnt_d == '0);
            fail_d  = (err_cnt_d != '0);
          end else begin
            k_d = k_q + IDX_W'(1);
          end
`else
          if (mismatch) begin
            fail_idx_d  = k_q;
            fail_data_d = rf_if.rf_data;
            fail_d      = 1'b1;
            state_d     = S_DONE;
          end else if (k_q == LAST_IDX) begin
            pass_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            k_d = k_q + IDX_W'(1);
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cycle_cnt_q  <= '0;
      drain_cnt_q  <= '0;
      k_q          <= '0;
      stop_cause_q <= 2'd0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_idx_q   <= '0;
      fail_data_q  <= '0;
`ifdef JEDRO_1_MON_ERR_CNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cycle_cnt_q  <= cycle_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      k_q          <= k_d;
      stop_cause_q <= stop_cause_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      fail_idx_q   <= fail_idx_d;
      fail_data_q  <= fail_data_d;
`ifdef JEDRO_1_MON_ERR_CNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign rf_if.rf_addr = rf_addr;
  assign busy_o        = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_CHECK);
  assign done_o        = (state_q == S_DONE);
  assign pass_o        = pass_q;
  assign fail_o        = fail_q;
  assign stop_cause_o  = stop_cause_q;
  assign fail_idx_o    = fail_idx_q;
  assign fail_data_o   = fail_data_q;
  assign cycle_cnt_o   = cycle_cnt_q;
`ifdef JEDRO_1_MON_ERR_CNT_EN
  assign err_cnt_o     = err_cnt_q;
`endif

endmodule

// File: tb/tb_jedro_1_test_monitor.sv
// Directed bench for jedro_1_test_monitor: predicted results are queued per run and compared at done.
module tb_jedro_1_test_monitor;
  localparam int DW = 32, AW = 5, NC = 2, MAXC = 32, DRC = 3, CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, illegal = 1'b0, halt = 1'b0;
  logic start0 = 1'b0, halt0 = 1'b0;
  logic [31:0] rf [32];
  logic [NC*AW-1:0] exp_addr = {5'd2, 5'd1};
  logic [NC*DW-1:0] exp_data = {32'd15, 32'd15};

  logic busy, done, pass, fail;
  logic [1:0] cause;
  logic [1:0] fidx;
  logic [DW-1:0] fdata;
  logic [CW-1:0] cyc;
  logic busy0, done0, pass0, fail0;
  logic [1:0] cause0;
  logic [0:0] fidx0;
  logic [DW-1:0] fdata0;
  logic [CW-1:0] cyc0;
`ifdef JEDRO_1_MON_ERR_CNT_EN
  logic [CW-1:0] errc, errc0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pass;
    logic        fail;
    logic [1:0]  cause;
    int          cyc;
    int          idx;
    logic [31:0] data;
    int          errs;
    int          done_at;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  jedro_1_test_monitor_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) rf_if ();
  jedro_1_test_monitor_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) rf0_if ();
  assign rf_if.rf_data  = rf[rf_if.rf_addr];
  assign rf0_if.rf_data = 32'h0;

  jedro_1_test_monitor #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_CHECKS(NC),
    .MAX_CYCLES(MAXC), .DRAIN_CYCLES(DRC), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .illegal_instr_i(illegal), .halt_i(halt),
    .exp_addr_i(exp_addr), .exp_data_i(exp_data), .rf_if(rf_if),
    .busy_o(busy), .done_o(done), .pass_o(pass), .fail_o(fail), .stop_cause_o(cause),
    .fail_idx_o(fidx), .fail_data_o(fdata),
`ifdef JEDRO_1_MON_ERR_CNT_EN
    .err_cnt_o(errc),
`endif
    .cycle_cnt_o(cyc)
  );

  jedro_1_test_monitor #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_CHECKS(0),
    .MAX_CYCLES(MAXC), .DRAIN_CYCLES(0), .CNT_WIDTH(CW)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .illegal_instr_i(1'b0), .halt_i(halt0),
    .exp_addr_i(5'd0), .exp_data_i(32'd0), .rf_if(rf0_if),
    .busy_o(busy0), .done_o(done0), .pass_o(pass0), .fail_o(fail0), .stop_cause_o(cause0),
    .fail_idx_o(fidx0), .fail_data_o(fdata0),
`ifdef JEDRO_1_MON_ERR_CNT_EN
    .err_cnt_o(errc0),
`endif
    .cycle_cnt_o(cyc0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected values are 15 at x1 (check 0) and x2 (check 1).
  function automatic exp_t predict(input int ill, input int hlt, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [31:0] got [2];
    int s, first, nchk;
    s = MAXC - 1;
    e.cause = 2'd2;
    if (hlt >= 0 && hlt <= s) begin s = hlt; e.cause = 2'd3; end
    if (ill >= 0 && ill <= s) begin s = ill; e.cause = 2'd1; end
    e.cyc = s + 1;
    got[0] = r1;
    got[1] = r2;
    first = -1;
    e.errs = 0;
    for (int k = 0; k < 2; k++) begin
      if (got[k] != 32'd15) begin
        e.errs++;
        if (first < 0) first = k;
      end
    end
`ifdef JEDRO_1_MON_ERR_CNT_EN
    nchk = 2;
`else
    nchk = (first >= 0) ? first + 1 : 2;
`endif
    e.pass    = (first < 0);
    e.fail    = (first >= 0);
    e.idx     = (first < 0) ? 0 : first;
    e.data    = (first < 0) ? 32'd0 : got[first];
    e.done_at = s + DRC + nchk + 1;
    return e;
  endfunction

  task automatic run(input string name, input int ill, input int hlt, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int d;
    rf[1] = r1;
    rf[2] = r2;
    sb.push_back(predict(ill, hlt, r1, r2));
    start = 1'b1;
    tick();
    start = 1'b0;
    d = -1;
    for (int j = 0; j < 200; j++) begin
      if (j == 0) check({name, ".cnt_clear"}, 64'(cyc), 64'd0);
      if (done) begin d = j; break; end
      illegal = (j == ill);
      halt    = (j == hlt);
      tick();
      illegal = 1'b0;
      halt    = 1'b0;
    end
    e = sb.pop_front();
    check({name, ".done_at"}, 64'(d), 64'(e.done_at));
    check({name, ".pass"}, 64'(pass), 64'(e.pass));
    check({name, ".fail"}, 64'(fail), 64'(e.fail));
    check({name, ".cause"}, 64'(cause), 64'(e.cause));
    check({name, ".cycles"}, 64'(cyc), 64'(e.cyc));
    check({name, ".fail_idx"}, 64'(fidx), 64'(e.idx));
    check({name, ".fail_data"}, 64'(fdata), 64'(e.data));
    check({name, ".busy"}, 64'(busy), 64'd0);
`ifdef JEDRO_1_MON_ERR_CNT_EN
    check({name, ".err_cnt"}, 64'(errc), 64'(e.errs));
`endif
    $display("run %s: pass=%0b fail=%0b cause=%0d cycles=%0d idx=%0d data=%0d done_at=%0d",
             name, pass, fail, cause, cyc, fidx, fdata, d);
  endtask

  // Start, halt at RUN cycle 2, then pulse reset at interval rst_at (4 = DRAIN, 6 = first CHECK).
  task automatic reset_probe(input string name, input int rst_at);
    rf[1] = 32'd15;
    rf[2] = 32'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < rst_at; j++) begin
      halt = (j == 2);
      tick();
      halt = 1'b0;
    end
    check({name, ".busy_before"}, 64'(busy), 64'd1);
    if (rst_at >= 6) check({name, ".rf_addr_k0"}, 64'(rf_if.rf_addr), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check({name, ".outs_zero"}, {busy, done, pass, fail, cause, fidx, rf_if.rf_addr, cyc}, 64'd0);
    check({name, ".cause_zero"}, 64'(cause), 64'd0);
    $display("reset %s at interval %0d: busy=%0b done=%0b cycles=%0d", name, rst_at, busy, done, cyc);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    repeat (3) tick();
    check("reset.outs", {busy, done, pass, fail, cause, fidx, rf_if.rf_addr, cyc}, 64'd0);
    check("reset.fail_data", 64'(fdata), 64'd0);
    check("reset.dut0", {busy0, done0, pass0, fail0, cause0, cyc0}, 64'd0);
    rst = 1'b0;
    tick();
    $display("reset released: busy=%0b done=%0b", busy, done);

    run("or_pass", 10, -1, 32'd15, 32'd15);
    run("or_x2_bad", 10, -1, 32'd15, 32'd14);
    run("or_both_bad", 10, -1, 32'd0, 32'd14);
    run("timeout", -1, -1, 32'd15, 32'd15);
    run("ill_and_halt", 5, 5, 32'd15, 32'd15);
    run("halt_31", -1, 31, 32'd15, 32'd15);

    reset_probe("drain", 4);
    reset_probe("check", 6);
    run("after_reset", -1, 3, 32'd15, 32'd15);

    // NUM_CHECKS=0, DRAIN_CYCLES=0: halt at RUN cycle 0 with a start that must be ignored.
    start0 = 1'b1;
    tick();
    halt0 = 1'b1;
    tick();
    start0 = 1'b0;
    halt0  = 1'b0;
    check("nc0.not_done_yet", 64'(done0), 64'd0);
    check("nc0.busy_check", 64'(busy0), 64'd1);
    tick();
    check("nc0.done", 64'(done0), 64'd1);
    check("nc0.pass", 64'(pass0), 64'd1);
    check("nc0.fail", 64'(fail0), 64'd0);
    check("nc0.cause", 64'(cause0), 64'd3);
    check("nc0.cycles", 64'(cyc0), 64'd1);
    $display("run nc0: done=%0b pass=%0b cause=%0d cycles=%0d", done0, pass0, cause0, cyc0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
